// File: rtl/seg7_rx_decoder_pkg.sv
// Shared 7-segment constants (active-low, bit0=a .. bit6=g) and receive FSM encoding.
// Also consumed by the display encoder, so the pattern values must stay in sync with it.
package seg7_rx_decoder_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_LO = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_rx_decoder_seg7_to_hex.sv
// Combinational active-low segment pattern -> hex nibble decode, with a flag for non-hex codes.
// Zero latency; no flow control.
module seg7_to_hex
  import seg7_rx_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       vld_o
);

  always_comb begin
    nib_o = 4'h0;
    vld_o = 1'b1;
    case (seg_i)
      SEG_0: nib_o = 4'h0;
      SEG_1: nib_o = 4'h1;
      SEG_2: nib_o = 4'h2;
      SEG_3: nib_o = 4'h3;
      SEG_4: nib_o = 4'h4;
      SEG_5: nib_o = 4'h5;
      SEG_6: nib_o = 4'h6;
      SEG_7: nib_o = 4'h7;
      SEG_8: nib_o = 4'h8;
      SEG_9: nib_o = 4'h9;
      SEG_A: nib_o = 4'hA;
      SEG_B: nib_o = 4'hB;
      SEG_C: nib_o = 4'hC;
      SEG_D: nib_o = 4'hD;
      SEG_E: nib_o = 4'hE;
      SEG_F: nib_o = 4'hF;
      default: vld_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Pairs decoded 7-segment digits (high then low) into bytes; flags bad codes and missing low digit.
// Results/pulses appear 1 clk after the sampling edge; no backpressure, every strobe is consumed.
module seg7_rx_decoder
  import seg7_rx_decoder_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       err_invalid,
  output logic       err_timeout,
  output logic       busy,
  output logic [7:0] byte_count
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [3:0]      hi_q, hi_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            err_inv_q, err_inv_d;
  logic            err_to_q, err_to_d;

  logic [3:0]      dec_nib;
  logic            dec_vld;

  seg7_to_hex u_dec (
    .seg_i (seg_in),
    .nib_o (dec_nib),
    .vld_o (dec_vld)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    timer_d     = timer_q;
    out_byte_d  = out_byte_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    err_inv_d   = 1'b0;
    err_to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seg_valid) begin
          if (dec_vld) begin
            hi_d    = dec_nib;
            timer_d = '0;
            state_d = ST_WAIT_LO;
          end else begin
            err_inv_d = 1'b1;
          end
        end
      end
      ST_WAIT_LO: begin
        // A strobe takes priority over the timer, even on the expiry cycle.
        if (seg_valid) begin
          state_d = ST_IDLE;
          if (dec_vld) begin
            out_byte_d  = {hi_q, dec_nib};
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 8'd1;
          end else begin
            err_inv_d = 1'b1;
          end
        end else if (timer_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      hi_q        <= 4'h0;
      timer_q     <= '0;
      out_byte_q  <= 8'h00;
      cnt_q       <= 8'h00;
      out_valid_q <= 1'b0;
      err_inv_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      timer_q     <= timer_d;
      out_byte_q  <= out_byte_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      err_inv_q   <= err_inv_d;
      err_to_q    <= err_to_d;
    end
  end

  assign out_byte    = out_byte_q;
  assign out_valid   = out_valid_q;
  assign err_invalid = err_inv_q;
  assign err_timeout = err_to_q;
  assign busy        = (state_q == ST_WAIT_LO);
  assign byte_count  = cnt_q;

endmodule
